// File: rtl/if_stage.sv
// Instruction fetch: PC, internal imem (write port), IF/ID register; stats when IF_STAGE_STATS_EN is defined.
// Latency: 1 cycle from pc to instruction_out; all outputs come straight from registers.
// Backpressure: freeze holds pc and IF/ID; branch_taken overrides freeze and injects one bubble.
module if_stage #(
    parameter int IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);
    localparam int AW = $clog2(IMEM_WORDS);

    logic [31:0] imem_q [IMEM_WORDS];

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] next_pc;
    logic [31:0] fetch_word;

    // Out-of-range address bits are deliberately ignored (memory wraps).
    logic unused_waddr;
    assign unused_waddr = ^{imem_waddr[31:AW+2], imem_waddr[1:0]};

    assign next_pc    = pc_q + 32'd4;
    assign fetch_word = imem_q[pc_q[AW+1:2]];

    always_comb begin
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        if (branch_taken) begin
            pc_d     = branch_addr;
            pc_out_d = 32'd0;
            instr_d  = 32'd0;
            valid_d  = 1'b0;
        end else if (!freeze) begin
            pc_d     = next_pc;
            pc_out_d = next_pc;
            instr_d  = fetch_word;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= 32'd0;
            pc_out_q <= 32'd0;
            instr_q  <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    // Write port is unaffected by reset; a same-edge read still sees the old word.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_waddr[AW+1:2]] <= imem_wdata;
        end
    end

    assign pc_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;

`ifdef IF_STAGE_STATS_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else if (branch_taken) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
        end else if (freeze) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign fetch_count = 32'd0;
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif

endmodule
